// File: rtl/dff_toggle_monitor_if.sv
// Record drain port of dff_toggle_monitor: a valid/ready view of the FIFO head.
// The master side, the monitor, drives the head record; the slave side drives ready.
interface dff_toggle_monitor_if #(
    parameter int CNT_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic             out_level;
    logic [CNT_W-1:0] out_len;

    modport master (
        output out_valid,
        output out_level,
        output out_len,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_level,
        input  out_len,
        output out_ready
    );
endinterface

// File: rtl/dff_toggle_monitor.sv
// Samples a 1-bit signal each clock and queues one (level, run-length) record per transition.
// Define DFF_MON_SYNC_EN to put a two-flop synchronizer in front of the sampling logic.
//
// state    | meaning
// ST_IDLE  | disabled or just reset; the next enabled edge loads a fresh run
// ST_ARMED | tracking a run of level d_q, length run_q
module dff_toggle_monitor #(
    parameter int CNT_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   d_in_i,
    input  logic                   en_i,
    dff_toggle_monitor_if.master   out_if,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   overflow_o
);
    localparam int                AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  RUN_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  RUN_ONE  = CNT_W'(1);
    localparam logic [AW:0]       FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]       PTR_ONE  = (AW + 1)'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t           state_q;
    logic             d_q;
    logic [CNT_W-1:0] run_q;

    logic [CNT_W:0]   mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             ovf_q;

    logic             d_s;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic [CNT_W:0]   head;

`ifdef DFF_MON_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_in_i};
        end
    end

    assign d_s = sync_q[1];
`else
    assign d_s = d_in_i;
`endif

    // Run tracker; dropping enable disarms so the interrupted run is never reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            d_q     <= 1'b0;
            run_q   <= '0;
        end else if (!en_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    d_q     <= d_s;
                    run_q   <= RUN_ONE;
                    state_q <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (d_s != d_q) begin
                        d_q   <= d_s;
                        run_q <= RUN_ONE;
                    end else if (run_q != RUN_MAX) begin
                        run_q <= run_q + RUN_ONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign push  = en_i && (state_q == ST_ARMED) && (d_s != d_q);
    assign pop   = out_if.out_valid && out_if.out_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full_o || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            if (push && full_o && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= {d_q, run_q};
        end
    end

    assign count_o    = wptr_q - rptr_q;
    assign full_o     = (count_o == FULL_CNT);
    assign overflow_o = ovf_q;

    assign head             = mem_q[rptr_q[AW-1:0]];
    assign out_if.out_valid = (count_o != '0);
    assign out_if.out_level = out_if.out_valid ? head[CNT_W] : 1'b0;
    assign out_if.out_len   = out_if.out_valid ? head[CNT_W-1:0] : '0;

endmodule

// File: tb/tb_dff_toggle_monitor.sv
// Directed bench for dff_toggle_monitor (CNT_W=4, DEPTH=8) with hand-computed records.
module tb_dff_toggle_monitor;
    localparam int CNT_W = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_in;
    logic       en;
    logic [3:0] count;
    logic       full;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int lv [10];
    int ln [10];

    dff_toggle_monitor_if #(.CNT_W(CNT_W)) mon_if ();

    dff_toggle_monitor #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in_i     (d_in),
        .en_i       (en),
        .out_if     (mon_if),
        .count_o    (count),
        .full_o     (full),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic chk_head(input string tag, input int level, input int len);
        chk({tag, "_valid"}, int'(mon_if.out_valid), 1);
        chk({tag, "_level"}, int'(mon_if.out_level), level);
        chk({tag, "_len"}, int'(mon_if.out_len), len);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, int'(mon_if.out_valid), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_len"}, int'(mon_if.out_len), 0);
        chk({tag, "_level"}, int'(mon_if.out_level), 0);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        d_in = 1'b0;
        mon_if.out_ready = 1'b0;

        // reset held with d_in toggling
        for (int i = 0; i < 2; i++) begin
            d_in = ~d_in;
            tick();
            chk_empty("rst_hold");
            chk("rst_hold_full", int'(full), 0);
            chk("rst_hold_ovf", int'(overflow), 0);
        end
        rst = 1'b0;
        tick();
        chk_empty("rst_rel");
        chk("rst_rel_full", int'(full), 0);
        chk("rst_rel_ovf", int'(overflow), 0);

        // basic run: 0 for 5 edges, 1 for 3 edges
        en = 1'b1;
        d_in = 1'b0;
        tick(5);
        chk("basic_valid_e5", int'(mon_if.out_valid), 0);
        d_in = 1'b1;
        tick();
        chk_head("basic_e6", 0, 5);
        chk("basic_count_e6", int'(count), 1);
        tick(2);
        d_in = 1'b0;
        tick();
        chk("basic_count_e9", int'(count), 2);
        chk_head("basic_e9", 0, 5);
        mon_if.out_ready = 1'b1;
        tick();
        chk_head("basic_pop1", 1, 3);
        chk("basic_count_pop1", int'(count), 1);
        tick();
        chk_empty("basic_pop2");
        mon_if.out_ready = 1'b0;

        // single-cycle toggles starting from level 1
        en = 1'b0;
        tick();
        en = 1'b1;
        d_in = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            d_in = ~d_in;
            tick();
        end
        chk("tog_count", int'(count), 4);
        for (int i = 0; i < 4; i++) begin
            chk_head("tog_rec", (i % 2 == 0) ? 1 : 0, 1);
            mon_if.out_ready = 1'b1;
            tick();
        end
        mon_if.out_ready = 1'b0;
        chk("tog_drained", int'(count), 0);

        // fill, push+pop while full, drop while full, drain
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_in = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            lv[k] = k % 2;
            ln[k] = (k % 3) + 1;
        end
        for (int k = 0; k < 8; k++) begin
            if (ln[k] > 1) tick(ln[k] - 1);
            d_in = ~d_in;
            tick();
        end
        chk("fill_count", int'(count), 8);
        chk("fill_full", int'(full), 1);
        chk("fill_ovf", int'(overflow), 0);
        tick(ln[8] - 1);
        d_in = ~d_in;
        mon_if.out_ready = 1'b1;
        tick();
        mon_if.out_ready = 1'b0;
        chk("pushpop_count", int'(count), 8);
        chk("pushpop_ovf", int'(overflow), 0);
        chk_head("pushpop_head", lv[1], ln[1]);
        d_in = ~d_in;
        tick();
        chk("drop_ovf", int'(overflow), 1);
        chk("drop_count", int'(count), 8);
        chk("drop_full", int'(full), 1);
        for (int i = 1; i < 9; i++) begin
            chk_head("drain_rec", lv[i], ln[i]);
            mon_if.out_ready = 1'b1;
            tick();
        end
        mon_if.out_ready = 1'b0;
        chk("drain_count", int'(count), 0);
        chk("drain_ovf_sticky", int'(overflow), 1);

        // saturation of a 20-edge run at 15
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sat_ovf_cleared", int'(overflow), 0);
        d_in = 1'b1;
        tick(20);
        d_in = 1'b0;
        tick();
        chk_head("sat_rec", 1, 15);
        mon_if.out_ready = 1'b1;
        tick();
        mon_if.out_ready = 1'b0;

        // enable dropped mid-run: interrupted run not reported
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_in = 1'b1;
        tick(3);
        en = 1'b0;
        d_in = 1'b0;
        tick(2);
        chk("en_off_count", int'(count), 0);
        en = 1'b1;
        tick();
        chk("en_rearm_count", int'(count), 0);
        tick();
        d_in = 1'b1;
        tick();
        chk("en_rec_count", int'(count), 1);
        chk_head("en_rec", 0, 2);

        // reset with 3 records queued
        d_in = 1'b0;
        tick();
        d_in = 1'b1;
        tick();
        chk("rstq_count", int'(count), 3);
        rst = 1'b1;
        tick();
        chk_empty("rstq_after");
        rst = 1'b0;
        tick(2);
        d_in = 1'b0;
        tick();
        chk_head("rstq_fresh", 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dff_toggle_monitor.md
# dff_toggle_monitor

Observation-side counterpart of the flip-flop stimulus benches. It samples a 1-bit signal (typically a flip-flop `Q`) on every clock, measures how many cycles the signal holds each level, and queues one (level, run-length) record per transition in a small FIFO. A bench or downstream checker drains the FIFO through a valid/ready port. This turns a toggling waveform back into the interval sequence that produced it, so timing can be checked without waveform inspection.

## Interface
- `CNT_W`, 16: run-length counter and record length width.
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `d_in`  in  1  monitored signal, synchronous to `clk`.
- `en`  in  1  monitor enable.
- `out_ready`  in  1  consumer accepts the head record.
- `out_valid`  out  1  FIFO non-empty.
- `out_level`  out  1  level of the completed run at the head.
- `out_len`  out  CNT_W  run length in cycles at the head.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `full`  out  1  occupancy == DEPTH.
- `overflow`  out  1  sticky; a record was dropped.

## Operation
- Internal state: `d_q` (last sampled level), `run` (CNT_W), `armed`, FIFO memory, read/write pointers with one extra wrap bit.
- Per rising edge, with `rst`=0 and `en`=1:
  - `armed`=0: load `d_q`←`d_in`, `run`←1, `armed`←1. No push.
  - `armed`=1, `d_in`==`d_q`: `run`←min(`run`+1, 2^CNT_W−1). The count saturates and holds.
  - `armed`=1, `d_in`!=`d_q`: push {`d_q`, `run`}, then `d_q`←`d_in`, `run`←1.
- `en`=0: `d_q` and `run` hold, no push, `armed`←0. Re-enabling starts a fresh run without emitting the interrupted one. The FIFO still pops.
- Pop: occurs on an edge where `out_valid`=1 and `out_ready`=1.
- Push while full, same edge as pop: both succeed and `count` is unchanged.
- Push while full, no pop: the record is dropped, `overflow`←1, and the FIFO is unchanged.
- `overflow` clears only on `rst`.
- `out_level`/`out_len` show the head entry while `out_valid`=1, and are 0 when empty.
- Records leave in push order. Pointers wrap modulo DEPTH.

## Timing
- Reset values: `out_valid`=0, `out_level`=0, `out_len`=0, `count`=0, `full`=0, `overflow`=0.
- Reset clears internal state: `armed`=0, `d_q`=0, `run`=0, pointers=0.
- Reset mid-run or with the FIFO non-empty discards all records and the partial run. No record is emitted for the partial run.
- Push latency: a transition sampled at edge N is written at edge N. `out_valid`/`count` reflect it after edge N.
- Pop latency: the head advances at the accepting edge. The next entry is visible immediately after it.
- A run of length L is reported as L exactly: the number of sampling edges at that level, counting the edge that loaded it.
- `out_ready` may be held high continuously. Throughput is one pop per cycle.

## Configuration
- `DFF_MON_SYNC_EN` defined:
  - `d_in` passes through a two-flop synchronizer before the monitor logic, adding exactly 2 cycles of push latency.
  - Run lengths are unchanged.
  - Synchronizer flops reset to 0.
- Undefined: `d_in` feeds the logic directly. No extra flops.

## Test plan
- Reset: hold `rst`=1 for 2 edges with `d_in` toggling. Require `out_valid`=0, `count`=0, `full`=0, `overflow`=0, `out_len`=0 throughout and on release.
- Basic run: `en`=1, `d_in`=0 for 5 edges, then 1 for 3 edges, then 0. Require records (0,5) then (1,3), with `out_valid` high after the 6th edge.
- Single-cycle toggles: `d_in` alternates every edge for 4 transitions. Require 4 records each with `out_len`=1, levels alternating starting at the first sampled level.
- Overflow: DEPTH=8, `out_ready`=0, 9 transitions. Require `full`=1 and `count`=8 after the 8th, `overflow`=1 after the 9th. Draining then yields the first 8 records in order.
- Full push+pop and saturation:
  - With the FIFO full, present a transition and `out_ready`=1 on the same edge. Require `count` to stay 8 and `overflow` to stay 0.
  - With CNT_W=4, hold a level for 20 edges. Require `out_len`=15.
- Enable/reset mid-run:
  - `en`=0 after 3 edges of a run, then re-enable. Require no record for the interrupted run.
  - Assert `rst` with 3 records queued. Require `count`=0 on the next edge.
